// File: rtl/div_meter_pkg.sv
// Shared types and defaults for the divider period meter.
// Holds the FSM state type and the counter ceiling helper.
package div_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    // Largest value a w-bit unsigned counter can hold.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer chain for an asynchronous input plus a
// one-cycle rising-edge pulse on the synchronized level.
module sync_edge_det
    import div_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic r,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s_d;

    // Shift the raw input through the chain; keep a delayed copy for edge detect.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            s_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign s    = chain[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/div_period_meter.sv
// Measures rise-to-rise period of a slow divided signal in clk cycles,
// flags lock and timeout. Macro DIV_METER_HIGH_EN enables high-time capture.
module div_period_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             r,
    input  logic             div_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s;
    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .r    (r),
        .d    (div_in),
        .s    (s),
        .rise (rise)
    );

    // Period FSM: first rise arms, later rises capture; saturation drops to IDLE.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state     <= IDLE;
            cnt       <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEAS;
                        cnt       <= ONE;
                        timeout_o <= 1'b0;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_o <= cnt;
                        valid_o  <= 1'b1;
                        locked_o <= (cnt == period_o);
                        cnt      <= ONE;
                    end else if (cnt == CMAX) begin
                        timeout_o <= 1'b1;
                        locked_o  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
            endcase
        end
    end

`ifdef DIV_METER_HIGH_EN
    logic [CNT_W-1:0] hcnt;

    // Count high cycles since the last rise; capture alongside the period.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            hcnt   <= '0;
            high_o <= '0;
        end else begin
            if (rise) begin
                hcnt <= ONE;
            end else if (s && hcnt != CMAX) begin
                hcnt <= hcnt + ONE;
            end
            if (state == MEAS && rise) begin
                high_o <= hcnt;
            end
        end
    end
`else
    logic unused_s;
    assign unused_s = s;
    assign high_o   = '0;
`endif

endmodule
